// File: rtl/fwd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | fwd_pkg
// | Shared forwarding-select encodings and hazard FSM state type.
// | Revision: 1.0
// +----------------------------------------------------------------------------
package fwd_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    LDBR_WAIT = 1'b1
  } fwd_state_e;

endpackage
`default_nettype wire

// File: rtl/fwd_src_cmp.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | fwd_src_cmp
// | Per-operand forward source match with EX/MEM over MEM/WB priority.
// | Revision: 1.0
// +----------------------------------------------------------------------------
module fwd_src_cmp
  import fwd_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic              ex_mem_regwrite,
  input  logic [REG_AW-1:0] ex_mem_rd,
  input  logic              mem_wb_regwrite,
  input  logic [REG_AW-1:0] mem_wb_rd,
  output logic [1:0]        sel
);

  logic exm_hit;
  logic mwb_hit;

  always_comb begin
    exm_hit = ex_mem_regwrite && (ex_mem_rd != '0) && (ex_mem_rd == src);
    mwb_hit = mem_wb_regwrite && (mem_wb_rd != '0) && (mem_wb_rd == src);
    sel     = FWD_RF;
    if (exm_hit) begin
      sel = FWD_EXMEM;
    end else if (mwb_hit) begin
      sel = FWD_MEMWB;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | fwd_hazard_unit
// | Operand forwarding, load-use/branch/long-latency stall generation.
// | Define FWD_BRANCH_FWD_EN to forward EX/MEM into compare-in-ID branches.
// | Revision: 1.0
// +----------------------------------------------------------------------------
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int MD_LAT  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ex_mem_regwrite,
  input  logic [REG_AW-1:0]         ex_mem_rd,
  input  logic                      mem_wb_regwrite,
  input  logic [REG_AW-1:0]         mem_wb_rd,
  input  logic                      id_ex_regwrite,
  input  logic                      id_ex_memread,
  input  logic [REG_AW-1:0]         id_ex_rd,
  input  logic [NUM_SRC*REG_AW-1:0] id_ex_src,
  input  logic [NUM_SRC*REG_AW-1:0] if_id_src,
  input  logic                      if_id_branch,
  input  logic                      md_start,
  input  logic [REG_AW-1:0]         md_rd,
  output logic [2*NUM_SRC-1:0]      alu_fwd_sel,
  output logic [NUM_SRC-1:0]        br_fwd_sel,
  output logic                      stall,
  output logic                      md_busy,
  output logic                      md_wb,
  output logic                      md_overrun
);

  localparam int CNT_W = 4;

  fwd_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [REG_AW-1:0] md_rd_q, md_rd_d;
  logic              overrun_q, overrun_d;

  logic [NUM_SRC-1:0] idex_hit;
  logic [NUM_SRC-1:0] md_hit;
  logic [NUM_SRC-1:0] br_exm_hit;

  generate
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      logic [REG_AW-1:0] if_id_s;
      logic [1:0]        br_sel;

      assign if_id_s = if_id_src[i*REG_AW +: REG_AW];

      fwd_src_cmp #(.REG_AW(REG_AW)) u_alu_cmp (
        .src             (id_ex_src[i*REG_AW +: REG_AW]),
        .ex_mem_regwrite (ex_mem_regwrite),
        .ex_mem_rd       (ex_mem_rd),
        .mem_wb_regwrite (mem_wb_regwrite),
        .mem_wb_rd       (mem_wb_rd),
        .sel             (alu_fwd_sel[2*i +: 2])
      );

      // Branch compare only ever takes the EX/MEM result, so MEM/WB is masked.
      fwd_src_cmp #(.REG_AW(REG_AW)) u_br_cmp (
        .src             (if_id_s),
        .ex_mem_regwrite (ex_mem_regwrite),
        .ex_mem_rd       (ex_mem_rd),
        .mem_wb_regwrite (1'b0),
        .mem_wb_rd       ('0),
        .sel             (br_sel)
      );

      assign br_exm_hit[i] = (br_sel == FWD_EXMEM);
      assign idex_hit[i]   = (id_ex_rd != '0) && (id_ex_rd == if_id_s);
      assign md_hit[i]     = (md_rd_q != '0) && (md_rd_q == if_id_s);
    end
  endgenerate

  logic ld_use_stall;
  logic br_idex_stall;
  logic br_exm_stall;
  logic md_stall;

  always_comb begin
    md_busy       = (cnt_q != '0);
    md_wb         = (cnt_q == CNT_W'(1));
    md_overrun    = overrun_q;
    ld_use_stall  = id_ex_memread && (|idex_hit);
    br_idex_stall = if_id_branch && id_ex_regwrite && (|idex_hit);
    md_stall      = md_busy && !md_wb && (|md_hit);
`ifdef FWD_BRANCH_FWD_EN
    br_exm_stall  = 1'b0;
    br_fwd_sel    = (state_q == IDLE) ? br_exm_hit : '0;
`else
    br_exm_stall  = if_id_branch && (|br_exm_hit);
    br_fwd_sel    = '0;
`endif
    stall = rst_n && (ld_use_stall || br_idex_stall || br_exm_stall ||
                      md_stall || (state_q == LDBR_WAIT));
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    md_rd_d   = md_rd_q;
    overrun_d = overrun_q;
`ifdef FWD_BRANCH_FWD_EN
    unique case (state_q)
      IDLE:      if (br_idex_stall && id_ex_memread) state_d = LDBR_WAIT;
      LDBR_WAIT: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
`else
    state_d = IDLE;
`endif
    if (md_start && !md_busy) begin
      cnt_d   = CNT_W'(MD_LAT);
      md_rd_d = md_rd;
    end else if (md_busy) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    if (md_start && md_busy) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      md_rd_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      md_rd_q   <= md_rd_d;
      overrun_q <= overrun_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | tb_fwd_hazard_unit
// | Directed table vectors plus multi-cycle sequences for fwd_hazard_unit.
// | Revision: 1.0
// +----------------------------------------------------------------------------
module tb_fwd_hazard_unit;

`ifdef FWD_BRANCH_FWD_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       ex_mem_regwrite, mem_wb_regwrite, id_ex_regwrite, id_ex_memread;
  logic [4:0] ex_mem_rd, mem_wb_rd, id_ex_rd, md_rd;
  logic [9:0] id_ex_src, if_id_src;
  logic       if_id_branch, md_start;
  logic [3:0] alu_fwd_sel;
  logic [1:0] br_fwd_sel;
  logic       stall, md_busy, md_wb, md_overrun;

  int tests = 0;
  int fails = 0;

  fwd_hazard_unit #(.REG_AW(5), .NUM_SRC(2), .MD_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_rd(ex_mem_rd),
    .mem_wb_regwrite(mem_wb_regwrite), .mem_wb_rd(mem_wb_rd),
    .id_ex_regwrite(id_ex_regwrite), .id_ex_memread(id_ex_memread),
    .id_ex_rd(id_ex_rd), .id_ex_src(id_ex_src), .if_id_src(if_id_src),
    .if_id_branch(if_id_branch), .md_start(md_start), .md_rd(md_rd),
    .alu_fwd_sel(alu_fwd_sel), .br_fwd_sel(br_fwd_sel), .stall(stall),
    .md_busy(md_busy), .md_wb(md_wb), .md_overrun(md_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ew;  logic [4:0] erd;
    logic       mw;  logic [4:0] mrd;
    logic       iw;  logic       imr; logic [4:0] ird;
    logic [4:0] is0; logic [4:0] is1;
    logic [4:0] fs0; logic [4:0] fs1;
    logic       br;
    logic [3:0] e_alu; logic [1:0] e_br; logic e_st;
  } vec_t;

  function automatic vec_t mk(input logic ew, input logic [4:0] erd,
                              input logic mw, input logic [4:0] mrd,
                              input logic iw, input logic imr, input logic [4:0] ird,
                              input logic [4:0] is0, input logic [4:0] is1,
                              input logic [4:0] fs0, input logic [4:0] fs1,
                              input logic br, input logic [3:0] e_alu,
                              input logic [1:0] e_br, input logic e_st);
    vec_t v;
    v.ew = ew; v.erd = erd; v.mw = mw; v.mrd = mrd;
    v.iw = iw; v.imr = imr; v.ird = ird;
    v.is0 = is0; v.is1 = is1; v.fs0 = fs0; v.fs1 = fs1; v.br = br;
    v.e_alu = e_alu; v.e_br = e_br; v.e_st = e_st;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clr();
    ex_mem_regwrite = 0; ex_mem_rd = 0; mem_wb_regwrite = 0; mem_wb_rd = 0;
    id_ex_regwrite = 0; id_ex_memread = 0; id_ex_rd = 0;
    id_ex_src = 0; if_id_src = 0; if_id_branch = 0; md_start = 0; md_rd = 0;
  endtask

  task automatic md_chk(input string tag, input logic b, input logic w, input logic s);
    chk({tag, "_busy"},  {31'd0, md_busy}, {31'd0, b});
    chk({tag, "_wb"},    {31'd0, md_wb},   {31'd0, w});
    chk({tag, "_stall"}, {31'd0, stall},   {31'd0, s});
  endtask

  vec_t vecs[13];

  initial begin
    // fields: ew erd mw mrd iw imr ird is0 is1 fs0 fs1 br | alu br stall
    vecs[0]  = mk(1,3, 1,3, 0,0,0, 3,4, 0,0, 0, 4'b0010, 2'b00, 0);
    vecs[1]  = mk(1,0, 1,3, 0,0,0, 3,4, 0,0, 0, 4'b0001, 2'b00, 0);
    vecs[2]  = mk(0,3, 1,3, 0,0,0, 3,3, 0,0, 0, 4'b0101, 2'b00, 0);
    vecs[3]  = mk(1,3, 1,4, 0,0,0, 4,3, 0,0, 0, 4'b1001, 2'b00, 0);
    vecs[4]  = mk(1,0, 1,0, 0,0,0, 0,0, 0,0, 0, 4'b0000, 2'b00, 0);
    vecs[5]  = mk(0,0, 0,0, 1,1,5, 0,0, 2,5, 0, 4'b0000, 2'b00, 1);
    vecs[6]  = mk(0,0, 0,0, 1,1,0, 0,0, 0,0, 0, 4'b0000, 2'b00, 0);
    vecs[7]  = mk(0,0, 0,0, 1,0,6, 0,0, 6,1, 0, 4'b0000, 2'b00, 0);
    vecs[8]  = mk(0,0, 0,0, 1,0,6, 0,0, 6,1, 1, 4'b0000, 2'b00, 1);
    vecs[9]  = mk(1,8, 0,0, 0,0,0, 0,0, 2,8, 1, 4'b0000, EN ? 2'b10 : 2'b00, !EN);
    vecs[10] = mk(1,8, 0,0, 0,0,0, 0,0, 8,2, 0, 4'b0000, EN ? 2'b01 : 2'b00, 0);
    vecs[11] = mk(0,8, 0,0, 0,0,0, 0,0, 8,2, 1, 4'b0000, 2'b00, 0);
    vecs[12] = mk(0,0, 0,0, 0,0,6, 0,0, 6,2, 1, 4'b0000, 2'b00, 0);

    clr();
    rst_n = 0;
    id_ex_memread = 1; id_ex_rd = 5; if_id_src = {5'd5, 5'd0};
    #2;
    md_chk("reset", 0, 0, 0);
    chk("reset_overrun", {31'd0, md_overrun}, 32'd0);
    @(negedge clk); rst_n = 1; clr();

    foreach (vecs[k]) begin
      @(negedge clk);
      ex_mem_regwrite = vecs[k].ew; ex_mem_rd = vecs[k].erd;
      mem_wb_regwrite = vecs[k].mw; mem_wb_rd = vecs[k].mrd;
      id_ex_regwrite = vecs[k].iw; id_ex_memread = vecs[k].imr; id_ex_rd = vecs[k].ird;
      id_ex_src = {vecs[k].is1, vecs[k].is0};
      if_id_src = {vecs[k].fs1, vecs[k].fs0};
      if_id_branch = vecs[k].br;
      #1;
      chk($sformatf("vec%0d_alu", k), {28'd0, alu_fwd_sel}, {28'd0, vecs[k].e_alu});
      chk($sformatf("vec%0d_br", k),  {30'd0, br_fwd_sel},  {30'd0, vecs[k].e_br});
      chk($sformatf("vec%0d_stall", k), {31'd0, stall}, {31'd0, vecs[k].e_st});
    end

    // Load-use: one stall, then load advances to EX/MEM and stall clears
    @(negedge clk); clr();
    id_ex_regwrite = 1; id_ex_memread = 1; id_ex_rd = 5; if_id_src = {5'd5, 5'd1};
    #1 chk("lu_c1_stall", {31'd0, stall}, 32'd1);
    @(negedge clk);
    id_ex_regwrite = 0; id_ex_memread = 0; id_ex_rd = 0;
    ex_mem_regwrite = 1; ex_mem_rd = 5;
    #1 chk("lu_c2_stall", {31'd0, stall}, 32'd0);

    // Branch after load: exactly two stall cycles
    @(negedge clk); clr();
    id_ex_regwrite = 1; id_ex_memread = 1; id_ex_rd = 7;
    if_id_src = {5'd2, 5'd7}; if_id_branch = 1;
    #1 chk("lb_c1_stall", {31'd0, stall}, 32'd1);
    @(negedge clk);
    id_ex_regwrite = 0; id_ex_memread = 0; id_ex_rd = 0;
    ex_mem_regwrite = 1; ex_mem_rd = 7;
    #1 chk("lb_c2_stall", {31'd0, stall}, 32'd1);
    chk("lb_c2_brsel", {30'd0, br_fwd_sel}, 32'd0);
    @(negedge clk);
    ex_mem_regwrite = 0; ex_mem_rd = 0; mem_wb_regwrite = 1; mem_wb_rd = 7;
    #1 chk("lb_c3_stall", {31'd0, stall}, 32'd0);
    chk("lb_c3_brsel", {30'd0, br_fwd_sel}, 32'd0);

    // Long-latency op: busy cycles 1..4, writeback in 4, stall in 1..3
    @(negedge clk); clr();
    md_start = 1; md_rd = 9; if_id_src = {5'd0, 5'd9};
    #1 md_chk("md_c0", 0, 0, 0);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk); md_start = 0;
      #1 md_chk($sformatf("md_c%0d", c), c <= 4, c == 4, c <= 3);
    end
    chk("md_overrun_clean", {31'd0, md_overrun}, 32'd0);

    // Restart while busy, then reset mid-operation
    @(negedge clk); clr();
    md_start = 1; md_rd = 9;
    @(negedge clk); md_start = 0;
    @(negedge clk); md_start = 1; md_rd = 12;
    #1 chk("ovr_c2_pre", {31'd0, md_overrun}, 32'd0);
    @(negedge clk); md_start = 0; if_id_src = {5'd9, 5'd12};
    #1 chk("ovr_c3_set", {31'd0, md_overrun}, 32'd1);
    md_chk("ovr_c3", 1, 0, 1);
    rst_n = 0;
    #1 md_chk("rst_mid", 0, 0, 0);
    chk("rst_mid_overrun", {31'd0, md_overrun}, 32'd0);
    @(negedge clk); rst_n = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1 md_chk($sformatf("post_rst%0d", c), 0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
